// File: rtl/bcd_field_cnt.sv
// Two-digit BCD field counter (seconds/minutes/hours) bounded to [MIN_VAL, MAX_VAL],
// with validated load and registered carry/borrow/load_err pulses for cascading.
module bcd_field_cnt #(
  parameter int MAX_VAL = 59,
  parameter int MIN_VAL = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       set,
  input  logic [3:0] new_tens,
  input  logic [3:0] new_ones,
  input  logic       inc,
  input  logic       dec,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       carry,
  output logic       borrow,
  output logic       at_max,
  output logic       at_min,
  output logic       load_err
);

  if (MAX_VAL > 99 || MAX_VAL < 1 || MIN_VAL < 0 || MIN_VAL >= MAX_VAL) begin : g_bad_param
    $error("bcd_field_cnt: need 0 <= MIN_VAL < MAX_VAL <= 99");
  end

  localparam logic [3:0] MAX_TENS = 4'(MAX_VAL / 10);
  localparam logic [3:0] MAX_ONES = 4'(MAX_VAL % 10);
  localparam logic [3:0] MIN_TENS = 4'(MIN_VAL / 10);
  localparam logic [3:0] MIN_ONES = 4'(MIN_VAL % 10);
  localparam logic [7:0] MAX_BCD  = {MAX_TENS, MAX_ONES};
  localparam logic [7:0] MIN_BCD  = {MIN_TENS, MIN_ONES};

  // Packed BCD pairs order the same as their decimal values, so range checks
  // compare the digit pair directly without any conversion.
  function automatic logic bcd_load_ok(input logic [3:0] t, input logic [3:0] o);
    logic [7:0] v;
    v = {t, o};
    return (t <= 4'd9) && (o <= 4'd9) && (v >= MIN_BCD) && (v <= MAX_BCD);
  endfunction

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    logic [7:0] r;
    if (v[3:0] == 4'd9) r = {v[7:4] + 4'd1, 4'd0};
    else                r = {v[7:4], v[3:0] + 4'd1};
    return r;
  endfunction

  function automatic logic [7:0] bcd_dec(input logic [7:0] v);
    logic [7:0] r;
    if (v[3:0] == 4'd0) r = {v[7:4] - 4'd1, 4'd9};
    else                r = {v[7:4], v[3:0] - 4'd1};
    return r;
  endfunction

  logic [7:0] val_p0, val_p1;
  logic       carry_p0, carry_p1;
  logic       borrow_p0, borrow_p1;
  logic       err_p0, err_p1;
  logic       max_w, min_w;

  assign max_w = (val_p1 == MAX_BCD);
  assign min_w = (val_p1 == MIN_BCD);

  // p0: next value and pulse decode; set wins over inc/dec, inc&&dec holds
  always_comb begin
    val_p0    = val_p1;
    carry_p0  = 1'b0;
    borrow_p0 = 1'b0;
    err_p0    = 1'b0;
    if (set) begin
      if (bcd_load_ok(new_tens, new_ones)) val_p0 = {new_tens, new_ones};
      else                                 err_p0 = 1'b1;
    end else if (inc && !dec) begin
      if (max_w) begin
        val_p0   = MIN_BCD;
        carry_p0 = 1'b1;
      end else begin
        val_p0 = bcd_inc(val_p1);
      end
    end else if (dec && !inc) begin
      if (min_w) begin
        val_p0    = MAX_BCD;
        borrow_p0 = 1'b1;
      end else begin
        val_p0 = bcd_dec(val_p1);
      end
    end
  end

  // p1: registered field value and one-cycle pulses
  always_ff @(posedge clk) begin
    if (reset) begin
      val_p1    <= MIN_BCD;
      carry_p1  <= 1'b0;
      borrow_p1 <= 1'b0;
      err_p1    <= 1'b0;
    end else begin
      val_p1    <= val_p0;
      carry_p1  <= carry_p0;
      borrow_p1 <= borrow_p0;
      err_p1    <= err_p0;
    end
  end

  assign tens     = val_p1[7:4];
  assign ones     = val_p1[3:0];
  assign carry    = carry_p1;
  assign borrow   = borrow_p1;
  assign load_err = err_p1;
  assign at_max   = max_w;
  assign at_min   = min_w;

endmodule

// File: tb/tb_bcd_field_cnt.sv
// Bench for bcd_field_cnt: a 59/0 field and a 12/1 field, directed scenarios plus
// random traffic, checked against a decimal-integer reference model.
module tb_bcd_field_cnt;

  logic       clk = 1'b0;
  logic       rst_i[2], set_i[2], inc_i[2], dec_i[2];
  logic [3:0] nt_i[2], no_i[2];
  logic [3:0] tens_o[2], ones_o[2];
  logic       carry_o[2], borrow_o[2], max_o[2], min_o[2], err_o[2];

  int m_max[2] = '{59, 12};
  int m_min[2] = '{0, 1};
  int m_val[2] = '{0, 1};
  bit m_c[2], m_b[2], m_e[2];
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  bcd_field_cnt d0 (
    .clk(clk), .reset(rst_i[0]), .set(set_i[0]), .new_tens(nt_i[0]), .new_ones(no_i[0]),
    .inc(inc_i[0]), .dec(dec_i[0]), .tens(tens_o[0]), .ones(ones_o[0]), .carry(carry_o[0]),
    .borrow(borrow_o[0]), .at_max(max_o[0]), .at_min(min_o[0]), .load_err(err_o[0])
  );

  bcd_field_cnt #(.MAX_VAL(12), .MIN_VAL(1)) d1 (
    .clk(clk), .reset(rst_i[1]), .set(set_i[1]), .new_tens(nt_i[1]), .new_ones(no_i[1]),
    .inc(inc_i[1]), .dec(dec_i[1]), .tens(tens_o[1]), .ones(ones_o[1]), .carry(carry_o[1]),
    .borrow(borrow_o[1]), .at_max(max_o[1]), .at_min(min_o[1]), .load_err(err_o[1])
  );

  function automatic logic [12:0] obs(input int k);
    return {tens_o[k], ones_o[k], carry_o[k], borrow_o[k], err_o[k], max_o[k], min_o[k]};
  endfunction

  function automatic logic [12:0] expv(input int k);
    return {4'(m_val[k] / 10), 4'(m_val[k] % 10), m_c[k], m_b[k], m_e[k],
            m_val[k] == m_max[k], m_val[k] == m_min[k]};
  endfunction

  // Reference behaviour in plain decimal arithmetic.
  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      m_c[k] = 0; m_b[k] = 0; m_e[k] = 0;
      if (rst_i[k]) begin
        m_val[k] = m_min[k];
      end else if (set_i[k]) begin
        int nv;
        nv = 10 * int'(nt_i[k]) + int'(no_i[k]);
        if (nt_i[k] <= 9 && no_i[k] <= 9 && nv >= m_min[k] && nv <= m_max[k]) m_val[k] = nv;
        else m_e[k] = 1;
      end else if (inc_i[k] && !dec_i[k]) begin
        if (m_val[k] == m_max[k]) begin m_val[k] = m_min[k]; m_c[k] = 1; end
        else m_val[k] = m_val[k] + 1;
      end else if (dec_i[k] && !inc_i[k]) begin
        if (m_val[k] == m_min[k]) begin m_val[k] = m_max[k]; m_b[k] = 1; end
        else m_val[k] = m_val[k] - 1;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    for (int k = 0; k < 2; k++) begin
      rst_i[k] = 0; set_i[k] = 0; inc_i[k] = 0; dec_i[k] = 0; nt_i[k] = 0; no_i[k] = 0;
    end
  endtask

  task automatic do_load(input int k, input int t, input int o);
    set_i[k] = 1; nt_i[k] = 4'(t); no_i[k] = 4'(o);
    tick();
  endtask

  task automatic test_reset();
    rst_i[0] = 1; rst_i[1] = 1; inc_i[0] = 1;
    tick();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (obs(k) !== expv(k)) begin
        errors++; $display("FAIL reset dut%0d: got %h want %h", k, obs(k), expv(k));
      end
    end
    checks++;
    if ({tens_o[1], ones_o[1], min_o[1], max_o[1]} !== {4'd0, 4'd1, 1'b1, 1'b0}) begin
      errors++; $display("FAIL reset_12h: got %h%h want 01", tens_o[1], ones_o[1]);
    end
  endtask

  task automatic test_inc_sweep();
    for (int i = 0; i < 60; i++) begin
      inc_i[0] = 1;
      tick();
      checks++;
      if (obs(0) !== expv(0)) begin
        errors++; $display("FAIL inc_sweep step%0d: got %h want %h", i, obs(0), expv(0));
      end
    end
    checks++;
    if ({tens_o[0], ones_o[0], carry_o[0]} !== {4'd0, 4'd0, 1'b1}) begin
      errors++; $display("FAIL inc_wrap: got %h%h c=%b want 00 c=1", tens_o[0], ones_o[0], carry_o[0]);
    end
    tick();
    checks++;
    if (carry_o[0] !== 1'b0) begin
      errors++; $display("FAIL carry_drop: got %b want 0", carry_o[0]);
    end
  endtask

  task automatic test_load_rollover();
    do_load(0, 4, 9);
    checks++;
    if ({tens_o[0], ones_o[0], err_o[0]} !== {4'd4, 4'd9, 1'b0}) begin
      errors++; $display("FAIL load49: got %h%h e=%b want 49 e=0", tens_o[0], ones_o[0], err_o[0]);
    end
    inc_i[0] = 1;
    tick();
    checks++;
    if ({tens_o[0], ones_o[0], carry_o[0]} !== {4'd5, 4'd0, 1'b0}) begin
      errors++; $display("FAIL inc49: got %h%h c=%b want 50 c=0", tens_o[0], ones_o[0], carry_o[0]);
    end
  endtask

  task automatic test_dec_wrap();
    rst_i[0] = 1;
    tick();
    for (int i = 0; i < 3; i++) begin
      dec_i[0] = 1;
      tick();
      checks++;
      if (obs(0) !== expv(0)) begin
        errors++; $display("FAIL dec_wrap step%0d: got %h want %h", i, obs(0), expv(0));
      end
    end
    checks++;
    if ({tens_o[0], ones_o[0], borrow_o[0]} !== {4'd5, 4'd7, 1'b0}) begin
      errors++; $display("FAIL dec_57: got %h%h b=%b want 57 b=0", tens_o[0], ones_o[0], borrow_o[0]);
    end
  endtask

  task automatic test_invalid_load();
    do_load(0, 2, 5);
    do_load(0, 6, 0);
    checks++;
    if ({tens_o[0], ones_o[0], err_o[0]} !== {4'd2, 4'd5, 1'b1}) begin
      errors++; $display("FAIL load60: got %h%h e=%b want 25 e=1", tens_o[0], ones_o[0], err_o[0]);
    end
    do_load(0, 1, 10);
    checks++;
    if (obs(0) !== expv(0)) begin
      errors++; $display("FAIL load1A: got %h want %h", obs(0), expv(0));
    end
    tick();
    checks++;
    if (err_o[0] !== 1'b0) begin
      errors++; $display("FAIL err_drop: got %b want 0", err_o[0]);
    end
  endtask

  task automatic test_min1_field();
    do_load(1, 1, 2);
    inc_i[1] = 1;
    tick();
    checks++;
    if ({tens_o[1], ones_o[1], carry_o[1]} !== {4'd0, 4'd1, 1'b1}) begin
      errors++; $display("FAIL h12_inc: got %h%h c=%b want 01 c=1", tens_o[1], ones_o[1], carry_o[1]);
    end
    dec_i[1] = 1;
    tick();
    checks++;
    if ({tens_o[1], ones_o[1], borrow_o[1]} !== {4'd1, 4'd2, 1'b1}) begin
      errors++; $display("FAIL h12_dec: got %h%h b=%b want 12 b=1", tens_o[1], ones_o[1], borrow_o[1]);
    end
    do_load(1, 0, 0);
    checks++;
    if (obs(1) !== expv(1)) begin
      errors++; $display("FAIL h12_load00: got %h want %h", obs(1), expv(1));
    end
  endtask

  task automatic test_simultaneous();
    do_load(0, 5, 9);
    inc_i[0] = 1; dec_i[0] = 1;
    tick();
    checks++;
    if ({tens_o[0], ones_o[0], carry_o[0], borrow_o[0]} !== {4'd5, 4'd9, 2'b00}) begin
      errors++; $display("FAIL incdec_hold: got %h want 59 no pulse", obs(0));
    end
    set_i[0] = 1; nt_i[0] = 3; no_i[0] = 0; inc_i[0] = 1;
    tick();
    checks++;
    if ({tens_o[0], ones_o[0], carry_o[0]} !== {4'd3, 4'd0, 1'b0}) begin
      errors++; $display("FAIL set_inc: got %h want 30 c=0", obs(0));
    end
    do_load(0, 5, 9);
    rst_i[0] = 1; inc_i[0] = 1;
    tick();
    checks++;
    if (obs(0) !== expv(0)) begin
      errors++; $display("FAIL rst_inc: got %h want %h", obs(0), expv(0));
    end
  endtask

  task automatic test_back_to_back();
    do_load(0, 5, 9);
    for (int i = 0; i < 2; i++) begin
      dec_i[0] = (i == 0); inc_i[0] = (i == 1);
      tick();
      checks++;
      if (obs(0) !== expv(0)) begin
        errors++; $display("FAIL b2b step%0d: got %h want %h", i, obs(0), expv(0));
      end
    end
    do_load(1, 1, 2);
    for (int i = 0; i < 13; i++) begin
      inc_i[1] = 1;
      tick();
      checks++;
      if (obs(1) !== expv(1)) begin
        errors++; $display("FAIL h12_sweep step%0d: got %h want %h", i, obs(1), expv(1));
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      for (int k = 0; k < 2; k++) begin
        rst_i[k] = ($urandom_range(0, 39) == 0);
        set_i[k] = ($urandom_range(0, 7) == 0);
        nt_i[k]  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 9));
        no_i[k]  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 9));
        inc_i[k] = 1'($urandom_range(0, 1));
        dec_i[k] = ($urandom_range(0, 2) == 0);
      end
      tick();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs(k) !== expv(k)) begin
          errors++; $display("FAIL random n%0d dut%0d: got %h want %h", n, k, obs(k), expv(k));
        end
      end
    end
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      rst_i[k] = 0; set_i[k] = 0; inc_i[k] = 0; dec_i[k] = 0; nt_i[k] = 0; no_i[k] = 0;
    end
    test_reset();
    test_inc_sweep();
    test_load_rollover();
    test_dec_wrap();
    test_invalid_load();
    test_min1_field();
    test_simultaneous();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
